// File: rtl/cache_tag_ctrl.sv
// Direct-mapped cache tag controller: flushes the tag RAM, looks up requests, and runs the refill handshake on a miss.
// Latency: a hit responds 1 cycle after the accept edge; a miss responds 2+N cycles after it, where N is the number of MISS cycles.
// Backpressure: req_ready is low outside IDLE and whenever flush_req is high; mem_req is held until mem_ack.
`timescale 1ns/1ps
module cache_tag_ctrl #(
   parameter int AWIDTH = 3,
   parameter int TWIDTH = 13,
   parameter int CWIDTH = 16
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [TWIDTH+AWIDTH-1:0] req_addr,
   input  logic                     flush_req,
   output logic                     busy,
   output logic                     resp_valid,
   output logic                     resp_hit,
   output logic                     mem_req,
   output logic [TWIDTH+AWIDTH-1:0] mem_addr,
   input  logic                     mem_ack,
   output logic [AWIDTH-1:0]        tag_addr,
   output logic [TWIDTH:0]          tag_din,
   output logic                     tag_we,
   input  logic [TWIDTH:0]          tag_dout,
   output logic [CWIDTH-1:0]        hit_count,
   output logic [CWIDTH-1:0]        miss_count
);

   localparam int RWIDTH = TWIDTH + AWIDTH;
   localparam logic [CWIDTH-1:0] CNT_MAX = '1;
   localparam logic [AWIDTH-1:0] IDX_LAST = '1;

   typedef enum logic [2:0] {FLUSH, IDLE, COMPARE, MISS, FILL} state_t;

   state_t              state;
   logic [AWIDTH-1:0]   idx;
   logic [RWIDTH-1:0]   lat_addr;
   logic [TWIDTH-1:0]   lat_tag;
   logic                hit;

   assign lat_tag  = lat_addr[RWIDTH-1:AWIDTH];
   assign mem_addr = lat_addr;
   assign busy     = (state != IDLE);

   // The RAM output is only meaningful in COMPARE, one cycle after the index was presented
   assign hit = tag_dout[TWIDTH] & (tag_dout[TWIDTH-1:0] == lat_tag);

   // State, flush index, latched request address and saturating statistics
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= FLUSH;
         idx        <= '0;
         lat_addr   <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         case (state)
            FLUSH: begin
               idx <= idx + 1'b1;
               if (idx == IDX_LAST) state <= IDLE;
            end
            IDLE: begin
               if (flush_req) begin
                  idx   <= '0;
                  state <= FLUSH;
               end else if (req_valid) begin
                  lat_addr <= req_addr;
                  state    <= COMPARE;
               end
            end
            COMPARE: begin
               if (hit) begin
                  if (hit_count != CNT_MAX) hit_count <= hit_count + 1'b1;
                  state <= IDLE;
               end else begin
                  state <= MISS;
               end
            end
            MISS: begin
               if (mem_ack) state <= FILL;
            end
            FILL: begin
               if (miss_count != CNT_MAX) miss_count <= miss_count + 1'b1;
               state <= IDLE;
            end
            default: state <= FLUSH;
         endcase
      end
   end

   // Output decode; reset gates every strobe so a refill is abandoned in the cycle reset_n falls
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_hit   = 1'b0;
      mem_req    = 1'b0;
      tag_we     = 1'b0;
      tag_din    = '0;
      tag_addr   = lat_addr[AWIDTH-1:0];
      case (state)
         FLUSH: begin
            tag_addr = idx;
            tag_we   = 1'b1;
         end
         IDLE: begin
            req_ready = !flush_req;
            // Present the index now so the synchronous RAM captures it on the accept edge
            if (!flush_req && req_valid) tag_addr = req_addr[AWIDTH-1:0];
         end
         COMPARE: begin
            resp_valid = hit;
            resp_hit   = hit;
         end
         MISS: begin
            mem_req = 1'b1;
         end
         FILL: begin
            tag_we     = 1'b1;
            tag_din    = {1'b1, lat_tag};
            resp_valid = 1'b1;
         end
         default: begin
            tag_we = 1'b0;
         end
      endcase
      if (!reset_n) begin
         req_ready  = 1'b0;
         resp_valid = 1'b0;
         resp_hit   = 1'b0;
         mem_req    = 1'b0;
         tag_we     = 1'b0;
         tag_din    = '0;
      end
   end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Directed bench for cache_tag_ctrl with a behavioural synchronous-read tag RAM.
// Counters are built narrow so saturation is reachable in a short run.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
`timescale 1ns/1ps
module tb_cache_tag_ctrl;
   localparam int AW = 3;
   localparam int TW = 13;
   localparam int CW = 3;

   logic            clock;
   logic            reset_n;
   logic            req_valid;
   logic            req_ready;
   logic [15:0]     req_addr;
   logic            flush_req;
   logic            busy;
   logic            resp_valid;
   logic            resp_hit;
   logic            mem_req;
   logic [15:0]     mem_addr;
   logic            mem_ack;
   logic [2:0]      tag_addr;
   logic [13:0]     tag_din;
   logic            tag_we;
   logic [13:0]     tag_dout;
   logic [2:0]      hit_count;
   logic [2:0]      miss_count;

   int checks = 0;
   int failures = 0;

   logic            preload;
   logic [13:0]     ram [0:7];

   cache_tag_ctrl #(.AWIDTH(AW), .TWIDTH(TW), .CWIDTH(CW)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .flush_req(flush_req), .busy(busy),
      .resp_valid(resp_valid), .resp_hit(resp_hit),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .tag_addr(tag_addr), .tag_din(tag_din), .tag_we(tag_we), .tag_dout(tag_dout),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Tag RAM model; preload fills it with valid entries so a missing flush shows up as a false hit
   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < 8; i++) ram[i] <= 14'h2246;
      end else if (tag_we) begin
         ram[tag_addr] <= tag_din;
      end
      tag_dout <= ram[tag_addr];
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; preload = 1'b1; req_valid = 1'b0; flush_req = 1'b0;
      mem_ack = 1'b0; req_addr = 16'h0;
      #1;
      checks++;
      if ({req_ready, resp_valid, mem_req, tag_we} !== 4'b0000) begin
         failures++; $display("FAIL reset_strobes got=%b want=0000", {req_ready, resp_valid, mem_req, tag_we});
      end
      tick; preload = 1'b0; tick;
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++;
         if ({tag_we, tag_addr, tag_din, req_ready, busy} !== {1'b1, i[2:0], 14'h0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL reset_flush_%0d got=%h want=%h", i,
               {tag_we, tag_addr, tag_din, req_ready, busy}, {1'b1, i[2:0], 14'h0, 1'b0, 1'b1});
         end
         tick;
      end
      #1;
      checks++;
      if ({req_ready, busy, tag_we, hit_count, miss_count} !== {3'b100, 3'd0, 3'd0}) begin
         failures++; $display("FAIL reset_idle got=%b want=100000000", {req_ready, busy, tag_we, hit_count, miss_count});
      end
      checks++;
      if ({ram[0], ram[1], ram[2], ram[3], ram[4], ram[5], ram[6], ram[7]} !== 112'h0) begin
         failures++; $display("FAIL reset_ram_cleared got=%h want=0", {ram[0], ram[1], ram[2], ram[3], ram[4], ram[5], ram[6], ram[7]});
      end
   endtask

   task automatic test_miss_fill;
      req_valid = 1'b1; req_addr = 16'h1235;
      #1;
      checks++;
      if ({req_ready, tag_addr, tag_we} !== {1'b1, 3'd5, 1'b0}) begin
         failures++; $display("FAIL miss_accept got=%b want=11010", {req_ready, tag_addr, tag_we});
      end
      tick; req_valid = 1'b0;
      #1;
      checks++;
      if ({resp_valid, busy, req_ready} !== 3'b010) begin
         failures++; $display("FAIL miss_compare got=%b want=010", {resp_valid, busy, req_ready});
      end
      tick;
      for (int k = 0; k < 3; k++) begin
         mem_ack = (k == 2);
         #1;
         checks++;
         if ({mem_req, mem_addr, resp_valid} !== {1'b1, 16'h1235, 1'b0}) begin
            failures++; $display("FAIL miss_memreq_%0d got=%h want=%h", k, {mem_req, mem_addr, resp_valid}, {1'b1, 16'h1235, 1'b0});
         end
         tick;
      end
      mem_ack = 1'b0;
      #1;
      checks++;
      if ({tag_we, tag_addr, tag_din, resp_valid, resp_hit, mem_req} !== {1'b1, 3'd5, 14'h2246, 3'b100}) begin
         failures++; $display("FAIL miss_fill got=%h want=%h", {tag_we, tag_addr, tag_din, resp_valid, resp_hit, mem_req},
            {1'b1, 3'd5, 14'h2246, 3'b100});
      end
      tick;
      #1;
      checks++;
      if ({miss_count, hit_count, req_ready, busy, ram[5]} !== {3'd1, 3'd0, 2'b10, 14'h2246}) begin
         failures++; $display("FAIL miss_done got=%h want=%h", {miss_count, hit_count, req_ready, busy, ram[5]},
            {3'd1, 3'd0, 2'b10, 14'h2246});
      end
   endtask

   task automatic test_hit;
      req_valid = 1'b1; req_addr = 16'h1235;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL hit_accept got=%b want=1", req_ready);
      end
      tick; req_valid = 1'b0;
      #1;
      checks++;
      if ({resp_valid, resp_hit, tag_we, mem_req} !== 4'b1100) begin
         failures++; $display("FAIL hit_resp got=%b want=1100", {resp_valid, resp_hit, tag_we, mem_req});
      end
      tick;
      #1;
      checks++;
      if ({hit_count, miss_count, busy} !== {3'd1, 3'd1, 1'b0}) begin
         failures++; $display("FAIL hit_counts got=%b want=0010010", {hit_count, miss_count, busy});
      end
   endtask

   task automatic test_back_to_back;
      // Accepted the cycle after the hit response; same index, different tag
      req_valid = 1'b1; req_addr = 16'h2235;
      #1;
      checks++;
      if ({req_ready, tag_addr} !== {1'b1, 3'd5}) begin
         failures++; $display("FAIL b2b_accept got=%b want=1101", {req_ready, tag_addr});
      end
      tick; req_valid = 1'b0; mem_ack = 1'b1;
      #1;
      checks++;
      if ({resp_valid, mem_req} !== 2'b00) begin
         failures++; $display("FAIL b2b_compare_miss got=%b want=00", {resp_valid, mem_req});
      end
      tick; mem_ack = 1'b0;
      #1;
      checks++;
      if ({mem_req, mem_addr, tag_we} !== {1'b1, 16'h2235, 1'b0}) begin
         failures++; $display("FAIL b2b_memreq got=%h want=%h", {mem_req, mem_addr, tag_we}, {1'b1, 16'h2235, 1'b0});
      end
      tick; mem_ack = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b1) begin
         failures++; $display("FAIL b2b_memreq_held got=%b want=1", mem_req);
      end
      tick; mem_ack = 1'b0;
      #1;
      checks++;
      if ({tag_we, tag_addr, tag_din, resp_valid, resp_hit} !== {1'b1, 3'd5, 14'h2446, 2'b10}) begin
         failures++; $display("FAIL b2b_fill got=%h want=%h", {tag_we, tag_addr, tag_din, resp_valid, resp_hit},
            {1'b1, 3'd5, 14'h2446, 2'b10});
      end
      tick;
      // Original tag was overwritten, so it now misses; ack arrives in the first MISS cycle
      req_valid = 1'b1; req_addr = 16'h1235;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL b2b_reaccept got=%b want=1", req_ready);
      end
      tick; req_valid = 1'b0;
      #1;
      checks++;
      if ({resp_valid, busy} !== 2'b01) begin
         failures++; $display("FAIL b2b_evicted_miss got=%b want=01", {resp_valid, busy});
      end
      tick; mem_ack = 1'b1;
      #1;
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 16'h1235}) begin
         failures++; $display("FAIL b2b_ack_first got=%h want=%h", {mem_req, mem_addr}, {1'b1, 16'h1235});
      end
      tick; mem_ack = 1'b0;
      #1;
      checks++;
      if ({tag_we, tag_din, resp_valid, resp_hit} !== {1'b1, 14'h2246, 2'b10}) begin
         failures++; $display("FAIL b2b_refill got=%h want=%h", {tag_we, tag_din, resp_valid, resp_hit}, {1'b1, 14'h2246, 2'b10});
      end
      tick;
      req_valid = 1'b1; req_addr = 16'h1235;
      #1;
      tick; req_valid = 1'b0;
      #1;
      checks++;
      if ({resp_valid, resp_hit} !== 2'b11) begin
         failures++; $display("FAIL b2b_rehit got=%b want=11", {resp_valid, resp_hit});
      end
      tick;
      #1;
      checks++;
      if ({hit_count, miss_count} !== {3'd2, 3'd3}) begin
         failures++; $display("FAIL b2b_counts got=%b want=010011", {hit_count, miss_count});
      end
   endtask

   task automatic test_flush_priority;
      flush_req = 1'b1; req_valid = 1'b1; req_addr = 16'h1235;
      #1;
      checks++;
      if ({req_ready, tag_we, busy} !== 3'b000) begin
         failures++; $display("FAIL flush_prio_idle got=%b want=000", {req_ready, tag_we, busy});
      end
      tick; flush_req = 1'b0; req_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++;
         if ({tag_we, tag_addr, tag_din, req_ready} !== {1'b1, i[2:0], 14'h0, 1'b0}) begin
            failures++; $display("FAIL flush_prio_%0d got=%h want=%h", i, {tag_we, tag_addr, tag_din, req_ready}, {1'b1, i[2:0], 14'h0, 1'b0});
         end
         tick;
      end
      req_valid = 1'b1; req_addr = 16'h1235;
      #1;
      checks++;
      if ({req_ready, busy} !== 2'b10) begin
         failures++; $display("FAIL flush_prio_ready got=%b want=10", {req_ready, busy});
      end
      tick; req_valid = 1'b0;
      #1;
      checks++;
      if ({resp_valid, busy} !== 2'b01) begin
         failures++; $display("FAIL flush_prio_miss got=%b want=01", {resp_valid, busy});
      end
      tick; mem_ack = 1'b1;
      #1;
      tick; mem_ack = 1'b0;
      #1;
      checks++;
      if ({resp_valid, resp_hit, tag_we} !== 3'b101) begin
         failures++; $display("FAIL flush_prio_fill got=%b want=101", {resp_valid, resp_hit, tag_we});
      end
      tick;
      #1;
      checks++;
      if ({miss_count, hit_count} !== {3'd4, 3'd2}) begin
         failures++; $display("FAIL flush_prio_counts got=%b want=100010", {miss_count, hit_count});
      end
   endtask

   task automatic test_reset_mid_miss;
      req_valid = 1'b1; req_addr = 16'h2235;
      #1;
      tick; req_valid = 1'b0;
      #1;
      tick;
      #1;
      checks++;
      if (mem_req !== 1'b1) begin
         failures++; $display("FAIL midmiss_memreq got=%b want=1", mem_req);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({mem_req, req_ready, tag_we, resp_valid} !== 4'b0000) begin
         failures++; $display("FAIL midmiss_drop got=%b want=0000", {mem_req, req_ready, tag_we, resp_valid});
      end
      tick; tick;
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++;
         if ({tag_we, tag_addr, tag_din, mem_req} !== {1'b1, i[2:0], 14'h0, 1'b0}) begin
            failures++; $display("FAIL midmiss_flush_%0d got=%h want=%h", i, {tag_we, tag_addr, tag_din, mem_req}, {1'b1, i[2:0], 14'h0, 1'b0});
         end
         tick;
      end
      #1;
      checks++;
      if ({hit_count, miss_count, req_ready, busy, mem_req, ram[5]} !== {6'd0, 3'b100, 14'h0}) begin
         failures++; $display("FAIL midmiss_after got=%h want=%h", {hit_count, miss_count, req_ready, busy, mem_req, ram[5]},
            {6'd0, 3'b100, 14'h0});
      end
   endtask

   task automatic test_saturation;
      req_valid = 1'b1; req_addr = 16'h1235;
      #1;
      tick; req_valid = 1'b0;
      #1;
      tick; mem_ack = 1'b1;
      #1;
      tick; mem_ack = 1'b0;
      #1;
      tick;
      for (int j = 0; j < 9; j++) begin
         req_valid = 1'b1;
         #1;
         tick; req_valid = 1'b0;
         #1;
         checks++;
         if ({resp_valid, resp_hit} !== 2'b11) begin
            failures++; $display("FAIL sat_hit_%0d got=%b want=11", j, {resp_valid, resp_hit});
         end
         tick;
         #1;
         checks++;
         if (hit_count !== ((j >= 6) ? 3'd7 : 3'(j + 1))) begin
            failures++; $display("FAIL sat_count_%0d got=%0d want=%0d", j, hit_count, (j >= 6) ? 7 : j + 1);
         end
      end
      checks++;
      if (miss_count !== 3'd1) begin
         failures++; $display("FAIL sat_misses got=%0d want=1", miss_count);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_miss_fill;
      test_hit;
      test_back_to_back;
      test_flush_priority;
      test_reset_mid_miss;
      test_saturation;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
